// File: rtl/sample_reader.sv
// rtl/sample_reader.sv - streams one LWE sample from BRAM with negacyclic negation of the mask
module sample_reader #(
    parameter int H_PARAM      = 1,
    parameter int K_PARAM      = 1,
    parameter int N_PARAM      = 1,
    parameter int ADDR_SIZE    = 32,
    parameter int VALUE_SIZE   = 32,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic                                    start_in,
    output logic [ADDR_SIZE-1:0]                    bram_addr_out,
    input  logic [VALUE_SIZE-1:0]                   bram_value_in,
    output logic [VALUE_SIZE-1:0]                   data_out,
    output logic [$clog2(K_PARAM*N_PARAM+1)-1:0]    index_out,
    output logic                                    valid_out,
    input  logic                                    ready_in,
    output logic                                    last_out,
    output logic                                    busy_out,
    output logic                                    done_out
);
    localparam int LAST_J = K_PARAM * N_PARAM;
    localparam int IDX_W  = $clog2(LAST_J + 1);
    localparam int DEPTH  = BRAM_LATENCY + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = 1 + IDX_W + VALUE_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_SIZE-1:0]    rd_addr;
    logic [BRAM_LATENCY-1:0] iss_pipe;
    logic [CNT_W-1:0]        inflight, count;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [IDX_W-1:0]        ret_j, ret_col;
    logic [ENT_W-1:0]        mem [DEPTH];
    logic                    launch, issue, arrive, pop, room, ret_neg, addr_last;
    logic [VALUE_SIZE-1:0]   ret_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bram_addr_out = rd_addr;
    assign arrive        = iss_pipe[BRAM_LATENCY-1];
    assign valid_out     = (count != '0);
    assign pop           = valid_out & ready_in;
    assign {last_out, index_out, data_out} = valid_out ? mem[rd_ptr] : '0;

    // A slot freed by this cycle's pop can be re-committed immediately, keeping one beat per cycle.
    assign room      = (int'(count) + int'(inflight) - int'(pop)) < DEPTH;
    assign launch    = (state == S_IDLE) && start_in;
    assign addr_last = (rd_addr == ADDR_SIZE'(LAST_J));
    assign issue     = launch || ((state == S_READ) && room);

    assign ret_neg  = (ret_j != IDX_W'(LAST_J)) && (int'(ret_col) > H_PARAM);
    assign ret_data = ret_neg ? (VALUE_SIZE'(0) - bram_value_in) : bram_value_in;

    always_comb begin
        state_nx = state;
        busy_out = 1'b0;
        done_out = 1'b0;
        case (state)
            S_IDLE:  if (start_in) state_nx = S_READ;
            S_READ: begin
                busy_out = 1'b1;
                if (room && addr_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy_out = 1'b1;
                if (pop && last_out) state_nx = S_DONE;
            end
            S_DONE: begin
                done_out = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= S_IDLE;
            rd_addr  <= '0;
            iss_pipe <= '0;
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ret_j    <= '0;
            ret_col  <= '0;
        end else begin
            state <= state_nx;
            // The start cycle itself issues address 0, so the READ state begins at address 1.
            if (issue)
                rd_addr <= ((state == S_READ) && addr_last) ? '0 : rd_addr + 1'b1;
            iss_pipe <= (iss_pipe << 1) | BRAM_LATENCY'(issue);
            inflight <= inflight + CNT_W'(issue) - CNT_W'(arrive);
            count    <= count + CNT_W'(arrive) - CNT_W'(pop);
            if (arrive) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            if (launch) begin
                ret_j   <= '0;
                ret_col <= '0;
            end else if (arrive) begin
                ret_j   <= ret_j + 1'b1;
                ret_col <= (ret_col == IDX_W'(N_PARAM - 1)) ? '0 : ret_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (arrive) mem[wr_ptr] <= {(ret_j == IDX_W'(LAST_J)), ret_j, ret_data};
    end
endmodule

// File: tb/tb_sample_reader.sv
// tb/tb_sample_reader.sv - directed scoreboard bench for sample_reader
module tb_sample_reader;
    localparam int K = 1, N = 4, H = 1, VS = 8, AS = 8, L = 2;
    localparam int KN = K * N;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          ready_in = 1'b1;
    logic [AS-1:0] bram_addr_out;
    logic [VS-1:0] bram_value_in;
    logic [VS-1:0] data_out;
    logic [2:0]    index_out;
    logic          valid_out, last_out, busy_out, done_out;

    sample_reader #(
        .H_PARAM(H), .K_PARAM(K), .N_PARAM(N),
        .ADDR_SIZE(AS), .VALUE_SIZE(VS), .BRAM_LATENCY(L)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .bram_addr_out(bram_addr_out), .bram_value_in(bram_value_in),
        .data_out(data_out), .index_out(index_out), .valid_out(valid_out),
        .ready_in(ready_in), .last_out(last_out), .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    logic [VS-1:0] bram [0:7];
    logic [VS-1:0] pipe0, pipe1;
    always @(posedge clk_in) begin
        pipe0 <= bram[bram_addr_out[2:0]];
        pipe1 <= pipe0;
    end
    assign bram_value_in = pipe1;

    typedef struct {
        int            j;
        logic [VS-1:0] data;
        logic          last;
    } beat_t;
    beat_t sb[$];
    beat_t e;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    int dones = 0;
    bit held_v = 0;
    logic [VS-1:0] h_data;
    logic [2:0]    h_idx;
    logic          h_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VS-1:0] exp_data(input int j);
        int v;
        v = int'(bram[j]);
        if (j < KN && (j % N) > H) v = (256 - v) % 256;
        return VS'(v);
    endfunction

    task automatic push_expected();
        beat_t b;
        for (int j = 0; j <= KN; j++) begin
            b.j    = j;
            b.data = exp_data(j);
            b.last = (j == KN);
            sb.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_sample();
        push_expected();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    task automatic run_until_done(input int mode, input int max_cycles);
        int d0;
        d0 = dones;
        for (int i = 0; i < max_cycles; i++) begin
            ready_in = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            step();
            if (dones > d0) break;
        end
        ready_in = 1'b1;
        chk("done_seen", 32'(dones - d0), 32'd1);
    endtask

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            held_v = 0;
        end else begin
            if (done_out) dones++;
            if (valid_out) begin
                if (held_v) begin
                    chk("hold_data", 32'(data_out), 32'(h_data));
                    chk("hold_idx", 32'(index_out), 32'(h_idx));
                    chk("hold_last", 32'(last_out), 32'(h_last));
                end
                if (ready_in) begin
                    if (sb.size() == 0) begin
                        chk("extra_beat", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_idx", 32'(index_out), 32'(e.j));
                        chk("beat_data", 32'(data_out), 32'(e.data));
                        chk("beat_last", 32'(last_out), 32'(e.last));
                    end
                    beats++;
                    held_v = 0;
                end else begin
                    held_v = 1;
                    h_data = data_out;
                    h_idx  = index_out;
                    h_last = last_out;
                end
            end else begin
                if (held_v) chk("valid_drop", 32'(valid_out), 32'd1);
                held_v = 0;
            end
        end
    end

    initial begin
        int b0, d0;
        bit reached;
        bram[0] = 8'd10; bram[1] = 8'd20; bram[2] = 8'd30; bram[3] = 8'd40;
        bram[4] = 8'd50; bram[5] = 8'd0;  bram[6] = 8'd0;  bram[7] = 8'd0;

        repeat (3) step();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_addr", 32'(bram_addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_idx", 32'(index_out), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        rst_n_in = 1'b1;
        step();

        // ready held high: latency L+1, back-to-back beats, single done
        start_sample();
        chk("busy_rise", 32'(busy_out), 32'd1);
        chk("valid_c1", 32'(valid_out), 32'd0);
        for (int cyc = 2; cyc <= 9; cyc++) begin
            step();
            chk($sformatf("valid_c%0d", cyc), 32'(valid_out), 32'((cyc >= 3) && (cyc <= 7)));
            chk($sformatf("done_c%0d", cyc), 32'(done_out), 32'(cyc == 8));
        end
        chk("s1_sb_empty", 32'(sb.size()), 32'd0);
        chk("s1_idle", 32'(busy_out), 32'd0);

        // ready toggling 1,0,0
        start_sample();
        run_until_done(1, 200);
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        // zero coefficient in a negated position
        bram[2] = 8'd0;
        start_sample();
        run_until_done(0, 100);
        chk("s3_sb_empty", 32'(sb.size()), 32'd0);
        bram[2] = 8'd30;

        // long back-pressure: reads stop at buffer depth
        ready_in = 1'b0;
        b0 = beats;
        start_sample();
        repeat (20) step();
        chk("s4_addr_stall", 32'(bram_addr_out), 32'(L + 1));
        chk("s4_valid", 32'(valid_out), 32'd1);
        chk("s4_idx", 32'(index_out), 32'd0);
        run_until_done(0, 100);
        chk("s4_beats", 32'(beats - b0), 32'd5);

        // reset mid-stream
        ready_in = 1'b1;
        b0 = beats;
        start_sample();
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            if (beats - b0 >= 2) begin
                reached = 1;
                break;
            end
            step();
        end
        chk("s5_two_beats", 32'(reached), 32'd1);
        rst_n_in = 1'b0;
        #2;
        chk("s5_valid", 32'(valid_out), 32'd0);
        chk("s5_last", 32'(last_out), 32'd0);
        chk("s5_busy", 32'(busy_out), 32'd0);
        chk("s5_done", 32'(done_out), 32'd0);
        chk("s5_addr", 32'(bram_addr_out), 32'd0);
        chk("s5_data", 32'(data_out), 32'd0);
        chk("s5_idx", 32'(index_out), 32'd0);
        sb.delete();
        repeat (2) step();
        rst_n_in = 1'b1;
        repeat (5) step();
        chk("s5_no_stale", 32'(valid_out), 32'd0);
        b0 = beats;
        start_sample();
        run_until_done(0, 100);
        chk("s5_beats", 32'(beats - b0), 32'd5);

        // start while busy is ignored
        d0 = dones;
        start_sample();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        run_until_done(0, 100);
        repeat (10) step();
        chk("s6_one_done", 32'(dones - d0), 32'd1);
        chk("s6_idle", 32'(busy_out), 32'd0);
        chk("s6_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
